// File: rtl/code_value_ram_ctrl.sv
// Sequencer/arbiter for the LZW code-value dictionary RAM: port B clear engine,
// round-robin lookup/update sharing of port A, and read-return address hold.
module code_value_ram_ctrl #(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned DATA_W     = 13,
   parameter int unsigned CLR_ROWS   = 1024,
   parameter int unsigned CLR_VALUE  = 0,
   parameter int unsigned CLR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   input  logic              lk_req,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_gnt,
   output logic              lk_rvalid,
   output logic [DATA_W-1:0] lk_rdata,
   input  logic              up_req,
   input  logic [ADDR_W-1:0] up_addr,
   input  logic [DATA_W-1:0] up_data,
   output logic              up_gnt,
   output logic              ram_en_porta,
   output logic              ram_wr_porta,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [DATA_W-1:0] ram_wr_dataa,
   input  logic [DATA_W-1:0] ram_rd_dataa,
   output logic              ram_en_portb,
   output logic              ram_wr_portb,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [DATA_W-1:0] ram_wr_datab
);

   localparam int unsigned CNT_W = (CLR_ROWS > 1) ? $clog2(CLR_ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RDRET = 2'd2
   } state_t;

   localparam state_t RST_STATE = (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  row_cnt, row_cnt_nx;
   logic              last_lk, last_lk_nx;
   logic              pend, pend_nx;
   logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
   logic              clear_done_nx;

   // State and bookkeeping registers. clear_busy doubles as the "clear writes
   // armed" flag, so the first post-reset cycle of an auto clear is a launch
   // cycle with no port B write and no enable can leak out during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RST_STATE;
         row_cnt    <= '0;
         last_lk    <= 1'b0;
         pend       <= 1'b0;
         rd_addr    <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         state      <= state_nx;
         row_cnt    <= row_cnt_nx;
         last_lk    <= last_lk_nx;
         pend       <= pend_nx;
         rd_addr    <= rd_addr_nx;
         clear_busy <= (state_nx == S_CLEAR);
         clear_done <= clear_done_nx;
      end
   end

   // Next-state, arbitration and RAM-facing outputs; everything is held low while rst is high.
   always_comb begin
      state_nx      = state;
      row_cnt_nx    = row_cnt;
      last_lk_nx    = last_lk;
      pend_nx       = pend;
      rd_addr_nx    = rd_addr;
      clear_done_nx = 1'b0;
      lk_gnt        = 1'b0;
      up_gnt        = 1'b0;
      lk_rvalid     = 1'b0;
      lk_rdata      = '0;
      ram_en_porta  = 1'b0;
      ram_wr_porta  = 1'b0;
      ram_addra     = rd_addr;
      ram_wr_dataa  = '0;
      ram_en_portb  = 1'b0;
      ram_wr_portb  = 1'b0;
      ram_addrb     = '0;
      ram_wr_datab  = '0;

      if (!rst) begin
         unique case (state)
            S_IDLE: begin
               if (clear_start || pend) begin
                  pend_nx  = 1'b0;
                  state_nx = S_CLEAR;
               end else if (lk_req && (!up_req || !last_lk)) begin
                  lk_gnt       = 1'b1;
                  ram_en_porta = 1'b1;
                  ram_addra    = lk_addr;
                  rd_addr_nx   = lk_addr;
                  last_lk_nx   = 1'b1;
                  state_nx     = S_RDRET;
               end else if (up_req) begin
                  up_gnt       = 1'b1;
                  ram_en_porta = 1'b1;
                  ram_wr_porta = 1'b1;
                  ram_addra    = up_addr;
                  ram_wr_dataa = up_data;
                  last_lk_nx   = 1'b0;
               end
            end
            S_RDRET: begin
               // addra stays on the read address: the RAM bank mux uses addra[1:0] now.
               lk_rvalid = 1'b1;
               lk_rdata  = ram_rd_dataa;
               if (clear_start) begin
                  pend_nx = 1'b1;
               end
               state_nx = S_IDLE;
            end
            S_CLEAR: begin
               if (clear_busy) begin
                  ram_en_portb = 1'b1;
                  ram_wr_portb = 1'b1;
                  ram_addrb    = ADDR_W'(row_cnt);
                  ram_wr_datab = DATA_W'(CLR_VALUE);
                  if (row_cnt == CNT_W'(CLR_ROWS - 1)) begin
                     row_cnt_nx    = '0;
                     clear_done_nx = 1'b1;
                     state_nx      = S_IDLE;
                  end else begin
                     row_cnt_nx = row_cnt + CNT_W'(1);
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/code_value_ram_ctrl.md
Name: code_value_ram_ctrl

Overview:
Sequencer and arbiter in front of the LZW code-value dictionary RAM (4 banks, 4096 x 13-bit, bank select addr[1:0], row addr[11:2]).
- Clears the dictionary through port B, writing all four banks per row, in CLR_ROWS cycles.
- Shares port A between the compressor lookup requester (read) and the dictionary update requester (write) with round-robin arbitration.
- Holds the read address for the RAM's one-cycle read-return window.

Parameters:
ADDR_W, 13, address width of both ports
DATA_W, 13, code value width
CLR_ROWS, 1024, rows cleared per clear sequence (port B addresses 0..CLR_ROWS-1)
CLR_VALUE, 0, value written during clear
CLR_ON_RST, 1, 1 = start a clear automatically on the first cycle after reset

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
clear_start  in  1  one-cycle pulse: start a dictionary clear
clear_busy  out  1  high while a clear is in progress
clear_done  out  1  one-cycle pulse after the last clear write
lk_req  in  1  lookup read request; held until granted
lk_addr  in  ADDR_W  lookup address
lk_gnt  out  1  combinational grant; read issued this cycle
lk_rvalid  out  1  lk_rdata valid; exactly one cycle after lk_gnt
lk_rdata  out  DATA_W  read data
up_req  in  1  update write request; held until granted
up_addr  in  ADDR_W  update address
up_data  in  DATA_W  update data
up_gnt  out  1  combinational grant; write issued this cycle
ram_en_porta  out  1  to RAM en_porta
ram_wr_porta  out  1  to RAM wr_porta
ram_addra  out  ADDR_W  to RAM addra
ram_wr_dataa  out  DATA_W  to RAM wr_dataa
ram_rd_dataa  in  DATA_W  from RAM rd_dataa
ram_en_portb  out  1  to RAM en_portb
ram_wr_portb  out  1  to RAM wr_portb
ram_addrb  out  ADDR_W  to RAM addrb; upper bits zero
ram_wr_datab  out  DATA_W  to RAM wr_datab

Behaviour:
- Reset values:
  - state = CLEAR if CLR_ON_RST, else IDLE.
  - clear row counter 0; rr pointer = lookup first.
  - All grants, clear_done, lk_rvalid and RAM enables/writes 0.
  - ram_addra and ram_addrb 0; lk_rdata 0.
  - clear_busy is registered and reads 0 during reset, then follows the state.
- States IDLE, CLEAR, RDRET.
- IDLE:
  - clear_start has priority over requests: no grant that cycle; go to CLEAR.
  - Otherwise arbitrate:
    - Only one requester active: it is granted.
    - Both active: the one not granted last wins; the rr pointer updates on every grant.
  - Lookup grant: ram_en_porta=1, ram_wr_porta=0, ram_addra=lk_addr; go to RDRET.
  - Update grant: ram_en_porta=1, ram_wr_porta=1, ram_addra=up_addr, ram_wr_dataa=up_data; stay in IDLE. Back-to-back writes run at 1 per cycle.
- RDRET:
  - ram_en_porta=0 and ram_addra holds the registered read address, because the RAM output mux uses addra[1:0] in this cycle.
  - lk_rvalid=1 and lk_rdata=ram_rd_dataa, both combinational.
  - No grants; return to IDLE. Read throughput is 1 per 2 cycles.
  - clear_start arriving in RDRET is latched as pending and serviced on entry to IDLE.
- CLEAR:
  - ram_en_portb=1, ram_wr_portb=1, ram_addrb=row counter, ram_wr_datab=CLR_VALUE. The counter increments every cycle.
  - No port A grants; requests wait.
  - After the write at row CLR_ROWS-1: pulse clear_done in the next cycle, clear the counter, go to IDLE.
  - clear_start while in CLEAR is ignored, with no restart.
- rst in any state aborts the current operation immediately. A partially cleared dictionary is re-cleared only if CLR_ON_RST=1.
- Write-then-read to the same address in consecutive cycles returns the new value, because the RAM write completes at the clock edge.
- Grants are never asserted without the matching req. RAM outputs are driven only from grant/state logic; no RAM enable is raised in reset.

Test Plan:
- Reset with CLR_ON_RST=1 -> clear_busy=1 for 1024 cycles, ram_addrb steps 0..1023 with wr_datab=0, clear_done pulses once, then IDLE.
- up_req addr=0x005 data=0x1A3, then lk_req addr=0x005 -> up_gnt in cycle N; lk_gnt in cycle N+1; lk_rvalid in cycle N+2 with lk_rdata=0x1A3 and ram_addra still 0x005.
- lk_req and up_req held continuously -> grants alternate lookup/update. Lookup grants never fall in an RDRET cycle, and a full read+write pair takes 3 cycles.
- lk_req addr=0x007 granted, then lk_req addr=0x004 -> the second grant comes 2 cycles later; the first lk_rdata comes from bank 3 and the second from bank 0.
- Requests held during clear_start -> no lk_gnt/up_gnt for 1024 cycles; both served after clear_done. Data previously written at 0x005 reads back 0x000.
- rst asserted mid-clear at row 300 with CLR_ON_RST=0 -> next cycle all RAM enables 0, state IDLE, clear_done never pulses.
